// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: slice width, FSM encoding and
// the index-width helper used to size the nibble counter.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nibble index width; a single-nibble operand still needs a 1-bit counter.
  function automatic int idx_width(input int nibbles);
    if (nibbles > 1) begin
      return $clog2(nibbles);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_add4.sv
// Combinational 4-bit ripple-carry slice; exposes the carry into the top bit
// (c3) as well as the carry out (c4) so signed overflow can be derived.
module nibble_add4
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             c3,
  output logic             c4
);

  logic [NIB_W:0] w_c;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = ci;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
  end

  assign c3 = w_c[NIB_W-1];
  assign c4 = w_c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder reusing one nibble slice, LSB nibble first.
// Define NSA_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef NSA_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_out_valid;
  logic               r_in_ready;
  logic               r_busy;

  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;
  logic [NIB_W-1:0]   w_s;
  logic               w_c4;

  // Bring the current nibble of each latched operand down to bit 0.
  assign w_a_shift = r_a >> {r_idx, 2'b00};
  assign w_b_shift = r_b >> {r_idx, 2'b00};

`ifdef NSA_OVF_EN
  logic w_c3;
  logic r_ovf;

  nibble_add4 u_slice (
    .a  (w_a_shift[NIB_W-1:0]),
    .b  (w_b_shift[NIB_W-1:0]),
    .ci (r_carry),
    .s  (w_s),
    .c3 (w_c3),
    .c4 (w_c4)
  );

  // Signed overflow is captured alongside cout on the MSB nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == ST_RUN) && (r_idx == LAST_IDX)) begin
      r_ovf <= w_c3 ^ w_c4;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  nibble_add4 u_slice (
    .a  (w_a_shift[NIB_W-1:0]),
    .b  (w_b_shift[NIB_W-1:0]),
    .ci (r_carry),
    .s  (w_s),
    .c3 (),
    .c4 (w_c4)
  );
`endif

  // Sequencer: accept, one nibble per RUN cycle, then hold the result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
              r_sum[i*NIB_W +: NIB_W] <= w_s;
            end
          end
          r_carry <= w_c4;
          if (r_idx == LAST_IDX) begin
            r_cout      <= w_c4;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          // in_ready stays low here even when the result drains this cycle.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
// Also exercises ovf when NSA_OVF_EN is defined.
module tb_nibble_serial_adder_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
`ifdef NSA_OVF_EN
  logic        ovf;
`endif

  int n_vec;
  int n_err;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef NSA_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and wait for its accept edge (bounded).
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) break;
      tick();
    end
    tick();
  endtask

  // Count edges after accept until out_valid rises; 99 means it never did.
  task automatic wait_done(output int cycles);
    cycles = 99;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_vec++; if (sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum got %h want 0000", sum); end
    n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    tick();
    rst = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int cyc;
    out_ready = 1'b1;
    start_op(16'h1234, 16'h4321, 1'b0);
    in_valid = 1'b0;
    n_vec++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL basic_run_flags got in_ready=%b busy=%b want 0 1", in_ready, busy); end
    wait_done(cyc);
    n_vec++; if (cyc != 4) begin n_err++; $display("FAIL basic_latency got %0d want 4", cyc); end
    n_vec++; if (sum !== 16'h5555 || cout !== 1'b0) begin n_err++; $display("FAIL basic_result got %h/%b want 5555/0", sum, cout); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_drain got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_carry_ripple();
    int cyc;
    out_ready = 1'b1;
    start_op(16'hFFFF, 16'h0000, 1'b1);
    in_valid = 1'b0;
    wait_done(cyc);
    n_vec++; if (cyc != 4 || sum !== 16'h0000 || cout !== 1'b1) begin
      n_err++; $display("FAIL ripple got cyc=%0d %h/%b want 4 0000/1", cyc, sum, cout);
    end
    tick();
  endtask

  task automatic test_overflow();
    int cyc;
    out_ready = 1'b1;
    start_op(16'h7FFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    wait_done(cyc);
    n_vec++; if (sum !== 16'h8000 || cout !== 1'b0) begin n_err++; $display("FAIL ovf_pos_result got %h/%b want 8000/0", sum, cout); end
`ifdef NSA_OVF_EN
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pos got %b want 1", ovf); end
`endif
    tick();
    start_op(16'h1000, 16'h2000, 1'b0);
    in_valid = 1'b0;
    wait_done(cyc);
    n_vec++; if (sum !== 16'h3000 || cout !== 1'b0) begin n_err++; $display("FAIL ovf_none_result got %h/%b want 3000/0", sum, cout); end
`ifdef NSA_OVF_EN
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_none got %b want 0", ovf); end
`endif
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    start_op(16'h0F0F, 16'h0101, 1'b0);
    in_valid = 1'b0;
    wait_done(cyc);
    n_vec++; if (cyc != 4 || sum !== 16'h1010 || cout !== 1'b0) begin
      n_err++; $display("FAIL bp_result got cyc=%0d %h/%b want 4 1010/0", cyc, sum, cout);
    end
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++; if (out_valid !== 1'b1 || sum !== 16'h1010 || cout !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL bp_hold%0d got ov=%b sum=%h c=%b ir=%b busy=%b want 1 1010 0 0 1", k, out_valid, sum, cout, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got ov=%b ir=%b want 0 1", out_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL bp_next_accept got ir=%b busy=%b want 0 1", in_ready, busy); end
    out_ready = 1'b1;
    wait_done(cyc);
    n_vec++; if (sum !== 16'hFFFF || cout !== 1'b0) begin n_err++; $display("FAIL bp_next_result got %h/%b want ffff/0", sum, cout); end
    tick();
  endtask

  task automatic test_input_change();
    int cyc;
    out_ready = 1'b1;
    start_op(16'h1111, 16'h2222, 1'b0);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    wait_done(cyc);
    n_vec++; if (cyc != 4 || sum !== 16'h3333 || cout !== 1'b0) begin
      n_err++; $display("FAIL latch_result got cyc=%0d %h/%b want 4 3333/0", cyc, sum, cout);
    end
    tick();
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL latch_idle got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    tick();
    in_valid = 1'b0;
    n_vec++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL latch_second_accept got ir=%b busy=%b want 0 1", in_ready, busy); end
    wait_done(cyc);
    n_vec++; if (cyc != 4 || sum !== 16'h0000 || cout !== 1'b1) begin
      n_err++; $display("FAIL latch_second_result got cyc=%0d %h/%b want 4 0000/1", cyc, sum, cout);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    out_ready = 1'b1;
    start_op(16'h1234, 16'h4321, 1'b0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_vec++; if (sum !== 16'h0000 || cout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL midrst got sum=%h c=%b ov=%b busy=%b want 0000 0 0 0", sum, cout, out_valid, busy);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_idle got ov=%b ir=%b want 0 1", out_valid, in_ready); end
    start_op(16'h0001, 16'h0001, 1'b0);
    in_valid = 1'b0;
    wait_done(cyc);
    n_vec++; if (cyc != 4 || sum !== 16'h0002 || cout !== 1'b0) begin
      n_err++; $display("FAIL midrst_after got cyc=%0d %h/%b want 4 0002/0", cyc, sum, cout);
    end
    tick();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    cin       = 1'b0;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_overflow();
    test_backpressure();
    test_input_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
